// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared widths, constants and helpers for the writeback block
package regfile_writeback_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Source of the write registered onto the register file port
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2
  } wb_src_e;

  // One-hot scoreboard mask for a register address
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// rtl/regfile_writeback_fifo.sv - load-result FIFO with wrap-bit pointers
module wb_load_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = REG_ADDR_W + XLEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] w_diff;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_diff = r_wr_ptr ^ r_rd_ptr;
  assign full   = (w_diff == {1'b1, {AW{1'b0}}});
  assign empty  = (w_diff == '0);
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset only empties the queue, storage is left as is
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop && !empty) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Entry storage written at the tail slot
  always_ff @(posedge clk) begin
    if (push && !full) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write port arbiter with load scoreboard
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int XLEN     = regfile_writeback_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [XLEN-1:0]       load_data,
  input  logic                  issue_valid,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_stall,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       rd_data
);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]       w_head_data;
  wb_src_e               w_sel;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;

  logic                  r_we;
  logic                  r_we_load;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_rd_data;
  logic [NUM_REGS-1:0]   r_busy;

  assign load_ready = !w_full;
  assign w_push     = load_valid && !w_full;

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH),
    .DW    (REG_ADDR_W + XLEN)
  ) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({load_rd, load_data}),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .dout  ({w_head_rd, w_head_data})
  );

  // Arbitration: ALU results cannot wait, so they win; x0 loads are popped without a write
  always_comb begin
    w_sel = WB_NONE;
    w_pop = 1'b0;
    if (alu_valid && alu_rd != REG_ZERO) begin
      w_sel = WB_ALU;
    end else if (!w_empty) begin
      w_pop = 1'b1;
      if (w_head_rd != REG_ZERO) w_sel = WB_LOAD;
    end
  end

  // Registered write port; address and data hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_we_load <= 1'b0;
      r_rd      <= '0;
      r_rd_data <= '0;
    end else begin
      case (w_sel)
        WB_ALU: begin
          r_we      <= 1'b1;
          r_we_load <= 1'b0;
          r_rd      <= alu_rd;
          r_rd_data <= alu_data;
        end
        WB_LOAD: begin
          r_we      <= 1'b1;
          r_we_load <= 1'b1;
          r_rd      <= w_head_rd;
          r_rd_data <= w_head_data;
        end
        default: begin
          r_we      <= 1'b0;
          r_we_load <= 1'b0;
        end
      endcase
    end
  end

  assign issue_stall = issue_valid && (r_busy[issue_rs1] || r_busy[issue_rs2] || r_busy[issue_rd]);

  assign w_set = (issue_valid && issue_is_load && !issue_stall && issue_rd != REG_ZERO)
               ? reg_mask(issue_rd) : '0;
  assign w_clr = (r_we && r_we_load) ? reg_mask(r_rd) : '0;

  // Scoreboard: a load write retiring clears its bit, a new load issue sets it and wins ties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~reg_mask(REG_ZERO);
    end
  end

  assign busy    = r_busy;
  assign we      = r_we;
  assign rd      = r_rd;
  assign rd_data = r_rd_data;

  a_load_has_pending_bit: assert property (
    @(posedge clk) disable iff (!rst)
    (w_push && load_rd != REG_ZERO) |-> r_busy[load_rd]
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        issue_valid;
  logic        issue_is_load;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [31:0] busy;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_writeback #(.LQ_DEPTH(4), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_rd       (load_rd),
    .load_data     (load_data),
    .issue_valid   (issue_valid),
    .issue_is_load (issue_is_load),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_stall   (issue_stall),
    .busy          (busy),
    .we            (we),
    .rd            (rd),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid     = 1'b0;
    alu_rd        = '0;
    alu_data      = '0;
    load_valid    = 1'b0;
    load_rd       = '0;
    load_data     = '0;
    issue_valid   = 1'b0;
    issue_is_load = 1'b0;
    issue_rs1     = '0;
    issue_rs2     = '0;
    issue_rd      = '0;
  endtask

  task automatic issue_load(input logic [4:0] r);
    issue_valid   = 1'b1;
    issue_is_load = 1'b1;
    issue_rs1     = '0;
    issue_rs2     = '0;
    issue_rd      = r;
    tick();
    issue_valid   = 1'b0;
    issue_is_load = 1'b0;
    issue_rd      = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    // reset hold with random inputs
    for (int i = 0; i < 5; i++) begin
      alu_valid   = 1'($urandom);
      alu_rd      = 5'($urandom);
      alu_data    = $urandom;
      load_valid  = 1'($urandom);
      load_rd     = 5'($urandom);
      load_data   = $urandom;
      tick();
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", load_ready, 1);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_we", we, 0);
    chk("post_rst_rd", rd, 0);
    chk("post_rst_data", rd_data, 0);
    chk("post_rst_busy", busy, 0);

    // ALU path
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk("alu_we", we, 1);
    chk("alu_rd", rd, 5);
    chk("alu_data", rd_data, 32'hDEADBEEF);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h11111111;
    tick();
    alu_valid = 1'b0;
    chk("alu_x0_we", we, 0);
    chk("alu_hold_rd", rd, 5);
    chk("alu_hold_data", rd_data, 32'hDEADBEEF);

    // load scoreboard
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
    #1 chk("issue_ld_nostall", issue_stall, 0);
    tick();
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = '0;
    chk("busy7_set", busy, 32'h0000_0080);
    issue_valid = 1'b1; issue_rs1 = 5'd7; issue_rd = 5'd1;
    #1 chk("raw_stall", issue_stall, 1);
    issue_valid = 1'b0; issue_rs1 = '0; issue_rd = '0;
    load_valid = 1'b1; load_rd = 5'd7; load_data = 32'h12345678;
    #1 chk("ld_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    chk("ld_n1_we", we, 0);
    tick();
    chk("ld_n2_we", we, 1);
    chk("ld_n2_rd", rd, 7);
    chk("ld_n2_data", rd_data, 32'h12345678);
    chk("ld_n2_busy", busy, 32'h0000_0080);
    tick();
    chk("ld_clr_busy", busy, 0);
    chk("ld_after_we", we, 0);
    issue_valid = 1'b1; issue_rs1 = 5'd7; issue_rd = 5'd1;
    #1 chk("stall_drop", issue_stall, 0);
    idle_inputs();

    // ALU priority over a waiting load
    issue_load(5'd3);
    chk("busy3_set", busy, 32'h0000_0008);
    load_valid = 1'b1; load_rd = 5'd3; load_data = 32'hAAAA0003;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + k); alu_data = 32'(100 + k);
      tick();
      chk("prio_alu_we", we, 1);
      chk("prio_alu_rd", rd, 10 + k);
      chk("prio_busy3", busy, 32'h0000_0008);
    end
    alu_valid = 1'b0;
    tick();
    chk("prio_ld_we", we, 1);
    chk("prio_ld_rd", rd, 3);
    chk("prio_ld_data", rd_data, 32'hAAAA0003);
    tick();
    chk("prio_busy_clr", busy, 0);

    // fill to full under ALU pressure, then drain, three rounds for pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) issue_load(5'(20 + i));
      chk("fill_busy", busy, 32'h00F0_0000);
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(r);
      for (int i = 0; i < 4; i++) begin
        load_valid = 1'b1; load_rd = 5'(20 + i); load_data = 32'hB000_0000 + 32'(r * 16 + i);
        #1 chk("fill_ready", load_ready, 1);
        tick();
      end
      load_valid = 1'b1; load_rd = 5'd20; load_data = 32'hFFFF_FFFF;
      #1 chk("full_ready", load_ready, 0);
      load_valid = 1'b0;
      alu_valid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (i == 0) chk("drain_ready", load_ready, 1);
        chk("drain_we", we, 1);
        chk("drain_rd", rd, 20 + i);
        chk("drain_data", rd_data, 32'hB000_0000 + 32'(r * 16 + i));
      end
      tick();
      chk("drain_busy", busy, 0);
      chk("drain_idle", we, 0);
    end

    // load to x0 is accepted and dropped without a write
    load_valid = 1'b1; load_rd = 5'd0; load_data = 32'h5555_5555;
    #1 chk("x0_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    tick();
    chk("x0_we_a", we, 0);
    tick();
    chk("x0_we_b", we, 0);

    // reset in the middle of buffered loads
    issue_load(5'd4);
    issue_load(5'd6);
    chk("mid_busy", busy, 32'h0000_0050);
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
    load_valid = 1'b1; load_rd = 5'd4; load_data = 32'h4;
    tick();
    load_rd = 5'd6; load_data = 32'h6;
    tick();
    load_valid = 1'b0;
    chk("mid_we_alu", we, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_ready", load_ready, 1);
    idle_inputs();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_mid_we", we, 0);
      chk("post_mid_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side companion to the CPU register file; owns its single write port (we, rd, rd_data).
- Merges single-cycle ALU results with multi-cycle load results from the memory unit.
- Buffers loads in a small FIFO and keeps a busy scoreboard of registers with outstanding loads.
- Gives the issue stage a stall signal for RAW/WAW hazards against pending loads.

Parameters:
- LQ_DEPTH, 4, load-result FIFO entries (power of two, >= 2)
- XLEN, 32, data width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- alu_valid  input  1  ALU result present this cycle; cannot be back-pressured
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- load_valid  input  1  load result offered
- load_ready  output  1  load result accepted when load_valid && load_ready
- load_rd  input  5  load destination register
- load_data  input  XLEN  load result
- issue_valid  input  1  issue stage presents an instruction
- issue_is_load  input  1  presented instruction is a load
- issue_rs1, issue_rs2, issue_rd  input  5 each  operand and destination registers of the presented instruction
- issue_stall  output  1  instruction must not issue this cycle
- busy  output  32  scoreboard, bit i = load to xi outstanding; bit 0 always 0
- we  output  1  register file write enable
- rd  output  5  register file write address
- rd_data  output  XLEN  register file write data

Behaviour:
- Reset (rst=0, async): we=0, rd=0, rd_data=0, busy=0, FIFO empty, load_ready=1. Reset mid-operation discards all buffered loads and pending bits.
- Write port outputs are registered:
  - ALU result in cycle N gives we=1 in cycle N+1.
  - Register file captures on the edge that ends N+1.
- Selection, per cycle:
  - if alu_valid && alu_rd!=0: register the ALU write; the FIFO head waits.
  - else if FIFO non-empty: pop head and register its write.
  - else: we<=0; rd and rd_data hold their previous values.
- rd==0 writes (ALU or load) are never driven: we stays 0 and no slot is consumed. A load to x0 is still accepted and dropped at the head without a write cycle.
- Load FIFO:
  - load_ready = !full. Enqueue on load_valid && load_ready.
  - Minimum load latency: accept at cycle N, we=1 at N+2.
  - Simultaneous enqueue and dequeue when full is not allowed, because load_ready is already 0.
  - Simultaneous enqueue and dequeue when non-full: occupancy is unchanged.
  - Pointers are log2(LQ_DEPTH)+1 bits and wrap modulo 2*LQ_DEPTH.
  - full = (wr_ptr^rd_ptr)=={1,0...}; empty = pointers equal.
- Scoreboard:
  - Set busy[issue_rd] on issue_valid && issue_is_load && !issue_stall && issue_rd!=0.
  - Clear busy[x] on the edge that ends a cycle with we=1 && rd==x for a load-sourced write. ALU writes never clear.
  - Set and clear of the same bit on the same edge: set wins.
- issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]); combinational from busy. The issue stage therefore never issues a write to a register with an outstanding load, so ALU and load writes to one rd are never reordered.
- A load that arrives for a register whose busy bit is 0 is a protocol violation. Assertion only; no recovery.
- ALU starvation of loads is permitted; no fairness counter.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, NUM_REGS=32, constant REG_ZERO=5'd0.
- Sub-module wb_load_fifo (LQ_DEPTH x {5, XLEN}):
  - push/pop/full/empty, head outputs combinational from storage.
  - Same clk/rst, reset clears pointers only.
- Top level holds the arbiter, output registers and scoreboard.

Test Plan:
- Reset hold: rst=0 with random inputs for 5 cycles -> we=0, busy=0, load_ready=1; release rst -> outputs unchanged until stimulus.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> cycle N+1 we=1, rd=5, rd_data=0xDEADBEEF; alu_rd=0 -> we stays 0.
- Load scoreboard:
  - Issue load rd=7 -> busy[7]=1.
  - Issue with rs1=7 -> issue_stall=1.
  - load_valid, rd=7, data=0x12345678 at N -> we=1, rd=7 at N+2; busy[7]=0 after that edge; stall drops.
- ALU priority: FIFO holds load rd=3; alu_valid for 3 consecutive cycles -> three ALU writes first, load write on the 4th cycle; busy[3] stays 1 until then.
- Full/backpressure: LQ_DEPTH=4 with continuous alu_valid -> load_ready=0 after 4 accepts. Drop alu_valid -> loads drain in FIFO order, 4 write cycles; load_ready=1 after the first pop; pointers wrap correctly over 3 fill/drain rounds.
- Reset mid-operation: 2 buffered loads with busy bits set, assert rst -> busy=0, we=0 immediately; no stale writes after release.
